// File: rtl/finv_arbiter_if.sv
// rtl/finv_arbiter_if.sv - request/response bundle between requesters, consumer and finv_arbiter
interface finv_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;

  modport master (
    output req_valid, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/finv_arbiter.sv
// rtl/finv_arbiter.sv - round-robin sharing of a fixed-latency reciprocal pipeline
// Credits cover in-flight slots plus FIFO occupancy so a result always finds room.
module finv_arbiter #(
  parameter int NREQ  = 4,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rstn,
  finv_arbiter_if.slave      bus,
  output logic [31:0]        finv_x,
  input  logic [31:0]        finv_y,
  output logic               busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LAT + 1);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic [31:0]     gnt_x;
  logic            xfer;
  logic            can_issue;
  logic [CW-1:0]   credit;
  logic [31:0]     x_arr [NREQ];

  logic [LAT-1:0]  pv;
  logic [IDW-1:0]  pid [LAT];

  logic [IDW+31:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      x_arr[i] = bus.req_x[32*i +: 32];
    end
  end

  // Credit is taken from registered state only; a pop this cycle frees nothing yet.
  always_comb begin
    credit = occ;
    for (int s = 0; s < LAT; s++) begin
      credit = credit + CW'(pv[s]);
    end
    can_issue = rstn && (credit < CW'(DEPTH));
  end

  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    grant  = '0;
    gnt_id = '0;
    gnt_x  = '0;
    xfer   = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!xfer && can_issue && bus.req_valid[idx]) begin
        xfer       = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = idx;
        gnt_x      = x_arr[idx];
      end
    end
  end

  assign bus.req_ready = grant;
  assign finv_x        = gnt_x;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
      pv  <= '0;
    end else begin
      if (xfer) begin
        ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      pv[0] <= xfer;
      for (int s = 1; s < LAT; s++) begin
        pv[s] <= pv[s-1];
      end
    end
  end

  // Tags need no reset: they are only consumed alongside a valid bit.
  always_ff @(posedge clk) begin
    pid[0] <= gnt_id;
    for (int s = 1; s < LAT; s++) begin
      pid[s] <= pid[s-1];
    end
  end

  assign push = pv[LAT-1];
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pid[LAT-1], finv_y};
    end
  end

  assign bus.rsp_valid              = (occ != '0);
  assign {bus.rsp_id, bus.rsp_data} = mem[rd_ptr];
  assign busy                       = (|pv) | bus.rsp_valid;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (occ == CW'(DEPTH))));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(grant));

endmodule

// File: tb/tb_finv_arbiter.sv
// tb/tb_finv_arbiter.sv - directed bench for finv_arbiter with finv model and in-order scoreboard
module tb_finv_arbiter;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F8  = 32'h41000000;
  localparam logic [31:0] F16 = 32'h41800000;
  localparam logic [31:0] FH  = 32'h3F000000;
  localparam logic [31:0] FN2 = 32'hC0000000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] finv_x;
  logic [31:0] finv_y;
  logic        busy;
  logic [31:0] xs [NREQ];
  logic [31:0] fp [LAT];
  logic [IDW+31:0] exp_q [$];
  logic [IDW+31:0] e;
  logic [3:0]  rr_exp [10];
  int n_cmp = 0;
  int n_bad = 0;
  int issued = 0;
  int rsp_seen = 0;
  int base;

  always #5 clk = ~clk;

  finv_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  finv_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus),
    .finv_x (finv_x),
    .finv_y (finv_y),
    .busy   (busy)
  );

  assign bus.req_x = {xs[3], xs[2], xs[1], xs[0]};

  // Operands are powers of two, so the reciprocal only reflects the exponent.
  function automatic logic [31:0] recip(input logic [31:0] x);
    return {x[31], 8'd254 - x[30:23], 23'd0};
  endfunction

  always @(posedge clk) begin
    fp[0] <= recip(finv_x);
    for (int s = 1; s < LAT; s++) fp[s] <= fp[s-1];
  end
  assign finv_y = fp[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      step();
      k++;
    end
    check("idle_reached", 64'(busy), 64'(1'b0));
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      issued = rsp_seen;
    end else begin
      check("grant_subset", 64'(bus.req_ready & ~bus.req_valid), 64'(4'h0));
      if (|bus.req_ready) begin
        check("grant_onehot", 64'($onehot(bus.req_ready)), 64'(1'b1));
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_ready[i]) begin
            check("finv_x", 64'(finv_x), 64'(xs[i]));
            exp_q.push_back({IDW'(i), recip(xs[i])});
            issued++;
          end
        end
      end
      if (dut.push) check("push_room", 64'(int'(dut.occ) < DEPTH), 64'(1'b1));
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_seen++;
        check("rsp_not_extra", 64'(rsp_seen <= issued), 64'(1'b1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(bus.rsp_id), 64'(e[IDW+31:32]));
          check("rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) xs[i] = '0;

    // reset state, with requests already pending
    repeat (2) @(posedge clk);
    #1 bus.req_valid = 4'hF;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'(4'h0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    bus.req_valid = '0;
    rstn = 1'b1;

    // 1: single request, latency LAT+1
    xs[2] = F2;
    bus.rsp_ready = 1'b1;
    step(); bus.req_valid = 4'b0100; #1;
    check("t1_grant", 64'(bus.req_ready), 64'(4'b0100));
    check("t1_finv_x", 64'(finv_x), 64'(F2));
    step(); bus.req_valid = '0; #1;
    check("t1_busy_c1", 64'(busy), 64'(1'b1));
    check("t1_early_c1", 64'(bus.rsp_valid), 64'(1'b0));
    repeat (2) begin
      step();
      check("t1_early", 64'(bus.rsp_valid), 64'(1'b0));
    end
    step();
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
    check("t1_rsp_id", 64'(bus.rsp_id), 64'(2'd2));
    check("t1_rsp_data", 64'(bus.rsp_data), 64'(32'h3F000000));
    step();
    check("t1_busy_after", 64'(busy), 64'(1'b0));
    check("t1_valid_after", 64'(bus.rsp_valid), 64'(1'b0));

    // 2: round robin from ptr 0; each transfer holds a credit for LAT+1 cycles
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    xs[0] = F2; xs[1] = F4; xs[2] = F8; xs[3] = F16;
    base = rsp_seen;
    for (int c = 0; c < 10; c++) begin
      step(); bus.req_valid = 4'hF; #1;
      check($sformatf("t2_grant_c%0d", c), 64'(bus.req_ready), 64'(rr_exp[c]));
    end
    step(); bus.req_valid = '0;
    wait_idle(30);
    check("t2_rsp_count", 64'(rsp_seen - base), 64'(8));

    // 3: back-pressure fills credits, issue resumes one cycle after the first pop
    xs[0] = F4;
    bus.rsp_ready = 1'b0;
    base = rsp_seen;
    for (int c = 0; c < 7; c++) begin
      step(); bus.req_valid = 4'b0001; #1;
      check($sformatf("t3_grant_c%0d", c), 64'(bus.req_ready), 64'((c < 4) ? 4'b0001 : 4'b0000));
    end
    step(); bus.rsp_ready = 1'b1; #1;
    check("t3_full_valid", 64'(bus.rsp_valid), 64'(1'b1));
    check("t3_full_data", 64'(bus.rsp_data), 64'(32'h3E800000));
    check("t3_no_credit_at_pop", 64'(bus.req_ready), 64'(4'b0000));
    step();
    check("t3_resume", 64'(bus.req_ready), 64'(4'b0001));
    step(); bus.req_valid = '0;
    wait_idle(30);
    check("t3_rsp_count", 64'(rsp_seen - base), 64'(5));

    // 4: pointer skip and wrap (ptr is 1 here)
    xs[0] = F2; xs[1] = F4; xs[2] = F8; xs[3] = F16;
    step(); bus.req_valid = 4'b0100; #1;
    check("t4_grant2", 64'(bus.req_ready), 64'(4'b0100));
    step(); bus.req_valid = 4'b0011; #1;
    check("t4_grant0", 64'(bus.req_ready), 64'(4'b0001));
    step(); #1;
    check("t4_grant1", 64'(bus.req_ready), 64'(4'b0010));
    step(); bus.req_valid = 4'b1000; #1;
    check("t4_grant3", 64'(bus.req_ready), 64'(4'b1000));
    step(); bus.req_valid = '0;
    wait_idle(30);
    bus.req_valid = 4'hF; #1;
    check("t4_wrap", 64'(bus.req_ready), 64'(4'b0001));
    step(); bus.req_valid = '0;
    wait_idle(30);

    // 5: stream with toggling rsp_ready
    xs[0] = F2; xs[1] = F8; xs[2] = FH; xs[3] = FN2;
    for (int c = 0; c < 40; c++) begin
      step();
      bus.req_valid = 4'hF;
      bus.rsp_ready = (c % 2 == 0);
    end
    step(); bus.req_valid = '0; bus.rsp_ready = 1'b1;
    wait_idle(40);
    check("t5_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t5_all_returned", 64'(rsp_seen), 64'(issued));

    // 6: reset with 2 in flight and 2 buffered
    xs[0] = F4;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(); bus.req_valid = 4'b0001;
    end
    step();
    check("t6_pre_busy", 64'(busy), 64'(1'b1));
    check("t6_pre_valid", 64'(bus.rsp_valid), 64'(1'b1));
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.rsp_valid), 64'(1'b0));
    check("t6_rst_busy", 64'(busy), 64'(1'b0));
    check("t6_rst_ready", 64'(bus.req_ready), 64'(4'b0000));
    step(); step();
    bus.req_valid = '0;
    rstn = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("t6_no_stale_c%0d", c), 64'({busy, bus.rsp_valid}), 64'(2'b00));
    end
    xs[1] = F8;
    bus.req_valid = 4'b0010; #1;
    check("t6_grant", 64'(bus.req_ready), 64'(4'b0010));
    step(); bus.req_valid = '0; #1;
    for (int c = 1; c < 4; c++) begin
      check($sformatf("t6_early_c%0d", c), 64'(bus.rsp_valid), 64'(1'b0));
      step();
    end
    check("t6_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
    check("t6_rsp_id", 64'(bus.rsp_id), 64'(2'd1));
    check("t6_rsp_data", 64'(bus.rsp_data), 64'(32'h3E000000));
    step();
    check("t6_idle", 64'(busy), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
